// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a four-state debounce FSM with registered
// level, edge-pulse and busy outputs. The output level feeds not_gate input p.
module input_debounce #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [1:0] ST_LOW       = 2'd0;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync0_q, sync1_q;
  logic             din_s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  // Metastability on din is confined to sync0_q; only sync1_q reaches the FSM.
  assign din_s = sync1_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (din_s) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      ST_WAIT_HIGH: begin
        if (!din_s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!din_s) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      ST_WAIT_LOW: begin
        if (din_s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
        dout_d  = 1'b0;
      end
    endcase
    busy_d = (state_d == ST_WAIT_HIGH) || (state_d == ST_WAIT_LOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      state_q <= ST_LOW;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync0_q <= din;
      sync1_q <= sync0_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule

// File: doc/input_debounce.md
Name: input_debounce

Overview:
- Conditioning stage directly upstream of the not_gate inverter.
- Takes a raw, asynchronous, bouncing input such as a switch or push-button.
- Synchronises it to clk and filters it, producing a clean level on dout that drives not_gate input p. It also produces single-cycle edge pulses.
- A level change on dout happens only after the synchronised input has held the new value for STABLE_CYCLES consecutive clock edges.

Parameters:
- STABLE_CYCLES, default 4: consecutive qualifying samples needed to accept a new level. Legal range is 2 to 2^CNT_W-1.
- CNT_W, default 8: width of the stability counter.

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- din, input, 1: raw asynchronous input.
- dout, output, 1: debounced level. Feeds not_gate input p.
- rise, output, 1: one-cycle pulse, asserted in the same cycle dout goes 0->1.
- fall, output, 1: one-cycle pulse, asserted in the same cycle dout goes 1->0.
- busy, output, 1: high while a candidate level change is being qualified.

Behaviour:
- Reset:
  - rst is sampled on the clk rising edge only.
  - Reset clears sync0, sync1, dout, rise, fall, busy and cnt to 0, and sets state to LOW.
  - rst has priority over every other event.
- Synchroniser:
  - Two flops: sync0 <= din, then sync1 <= sync0.
  - din_s = sync1 is the only signal the FSM sees. din is never used combinationally.
- FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW. All outputs are registered.
- LOW:
  - dout=0, busy=0.
  - If din_s=1: go to WAIT_HIGH, cnt <= 1.
- WAIT_HIGH:
  - busy=1, dout stays 0.
  - If din_s=0: go back to LOW, cnt <= 0.
  - Else if cnt == STABLE_CYCLES-1: go to HIGH, dout <= 1, rise <= 1, cnt <= 0.
  - Else: cnt <= cnt+1.
- HIGH and WAIT_LOW mirror LOW and WAIT_HIGH with polarity swapped. The accepting transition drives dout <= 0 and fall <= 1.
- rise and fall are 0 in every cycle except the one following an accepting transition. They are never both 1.
- busy is 1 exactly when state is WAIT_HIGH or WAIT_LOW.
- Latency:
  - If din changes before edge 1 and then stays stable, dout changes at edge STABLE_CYCLES+2.
  - With the default STABLE_CYCLES=4, dout changes at edge 6.
- Glitches: any din_s pulse shorter than STABLE_CYCLES samples produces no dout change and no pulse. The FSM returns to its previous stable state.
- Bounce: every reversal during a WAIT state aborts that wait. Qualification restarts from cnt=1 on the next opposite sample. There is no cumulative counting.
- Reset mid-operation:
  - A WAIT state is abandoned and dout goes to 0.
  - If din is held high through reset, a fresh qualification follows, and rise pulses at edge STABLE_CYCLES+2 after rst deasserts. The sync flops also restart from 0.
- Counter: cnt never exceeds STABLE_CYCLES-1, so there is no wrap-around.
- Metastability on din is contained in sync0 and is not visible at any output.

Test Plan:
- Reset values: hold din=1 and rst=1 for 3 cycles. Required: dout=0, rise=0, fall=0, busy=0 throughout the reset.
- Clean rise (STABLE_CYCLES=4): after reset, set din=1 before edge 1.
  - busy=1 after edges 3, 4 and 5.
  - dout=1 and rise=1 after edge 6.
  - rise=0 after edge 7, and busy=0 from edge 6 on.
- Glitch rejection: from LOW, pulse din=1 for 3 cycles, then din=0. Required: dout stays 0, no rise pulse, busy returns to 0.
- Bounce then settle:
  - From HIGH, apply din sequence 0,1,0,0,1,0 followed by steady 0.
  - Required: no fall pulse during the bounce.
  - fall=1 for exactly one cycle, 4 sampled-low edges after the last 1 reaches din_s, with dout=0 from then on.
- Reset mid-WAIT: assert rst while state is WAIT_HIGH and cnt=2, holding din=1.
  - Required: dout=0 and busy=0 after the reset edge.
  - rise pulses 6 edges after rst deasserts.
- Chain check: connect dout to not_gate p. Over a random bouncing din stimulus, q == ~dout at every sample, and q changes only on cycles where rise or fall is asserted.
